// File: rtl/sift_pkg.sv
// Shared constants and state encoding for the SIFT/DoG front-end sequencing logic.
package sift_pkg;

    localparam int DW     = 8;
    localparam int CNT_DW = 16;
    localparam int R      = 7;

    // A DoG output needs a full (R-1)-pixel neighbourhood margin, so outputs shrink by R-1.
    function automatic int out_dim(input int n);
        return n - (R - 1);
    endfunction

    localparam int WIDE_DEF  = 230;
    localparam int HIGN_DEF  = 235;
    localparam int OUT_W_DEF = WIDE_DEF - (R - 1);
    localparam int OUT_H_DEF = HIGN_DEF - (R - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } scan_st_e;

endpackage

// File: rtl/dog_scan_ctrl_raster_cnt.sv
// Column/row raster counter: column wraps at W-1 and bumps the row; flags the row end and frame end.
module raster_cnt #(
    parameter int W  = 8,
    parameter int H  = 6,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [CW-1:0] row_o,
    output logic          col_last_o,
    output logic          last_o
);

    logic [CW-1:0] col_q, row_q;
    logic          row_last;

    assign col_last_o = (col_q == CW'(W - 1));
    assign row_last   = (row_q == CW'(H - 1));
    assign last_o     = col_last_o && row_last;
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en_i) begin
            if (col_last_o) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + CW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dog_scan_ctrl.sv
// Frame sequencer: raster-feeds one image from pixel memory into the DoG stage and
// tags, counts and checks the DoG results for that frame.
module dog_scan_ctrl
    import sift_pkg::*;
#(
    parameter int WIDE      = WIDE_DEF,
    parameter int HIGN      = HIGN_DEF,
    parameter int DW        = sift_pkg::DW,
    parameter int AW        = 16,
    parameter int CNT_DW    = sift_pkg::CNT_DW,
    parameter int OUT_W     = out_dim(WIDE),
    parameter int OUT_H     = out_dim(HIGN),
    parameter int ROW_GAP   = 0,
    parameter int DRAIN_MAX = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_rd_data,
    output logic              dog_valid_in,
    output logic [DW-1:0]     dog_data_in,
    input  logic              dog_valid,
    output logic              out_valid,
    output logic [CNT_DW-1:0] out_col,
    output logic [CNT_DW-1:0] out_row
);

    localparam int DCW = $clog2(DRAIN_MAX + 1);
    localparam int GCW = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;

    scan_st_e          state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [GCW-1:0]    gap_q, gap_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic              err_q, err_d;
    logic              full_q, vin_q, ov_q;
    logic [CNT_DW-1:0] ocol_q, orow_q;
    logic              clr, accept, spurious;

    logic              in_col_last, in_last, o_last, o_col_last;
    logic [CNT_DW-1:0] in_col, in_row, o_col, o_row;
    logic              unused_flags;

    assign busy      = (state_q == ST_FEED) || (state_q == ST_GAP) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign mem_rd_en = (state_q == ST_FEED);
    assign mem_addr  = addr_q;
    assign frame_err = err_q;

    // Once the expected result count is reached, any further dog_valid is an error, not a result.
    assign accept   = dog_valid && busy && !full_q;
    assign spurious = dog_valid && !accept;

    raster_cnt #(.W(WIDE), .H(HIGN), .CW(CNT_DW)) u_in_cnt (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(mem_rd_en),
        .col_o(in_col), .row_o(in_row), .col_last_o(in_col_last), .last_o(in_last)
    );

    raster_cnt #(.W(OUT_W), .H(OUT_H), .CW(CNT_DW)) u_out_cnt (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(accept),
        .col_o(o_col), .row_o(o_row), .col_last_o(o_col_last), .last_o(o_last)
    );

    assign unused_flags = ^{in_col, in_row, o_col_last};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        drain_d = drain_q;
        err_d   = err_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_FEED;
                addr_d  = '0;
                err_d   = 1'b0;
                clr     = 1'b1;
            end
            ST_FEED: begin
                addr_d = addr_q + AW'(1);
                if (in_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else if (in_col_last && ROW_GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GCW'(ROW_GAP - 1)) state_d = ST_FEED;
                else                            gap_d   = gap_q + GCW'(1);
            end
            ST_DRAIN: begin
                if (full_q) begin
                    state_d = ST_DONE;
                end else if (drain_q == DCW'(DRAIN_MAX - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (spurious) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            gap_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            vin_q  <= 1'b0;
            ov_q   <= 1'b0;
            ocol_q <= '0;
            orow_q <= '0;
        end else begin
            vin_q <= mem_rd_en;
            ov_q  <= accept;
            if (clr)                   full_q <= 1'b0;
            else if (accept && o_last) full_q <= 1'b1;
            if (accept) begin
                ocol_q <= o_col;
                orow_q <= o_row;
            end
        end
    end

    // Read data lands one cycle after the strobe, exactly when the delayed valid is high.
    assign dog_valid_in = vin_q;
    assign dog_data_in  = vin_q ? mem_rd_data : '0;
    assign out_valid    = ov_q;
    assign out_col      = ocol_q;
    assign out_row      = orow_q;

endmodule

// File: tb/tb_dog_scan_ctrl.sv
// Bench for dog_scan_ctrl: an 8x6 frame through two instances (no row gap / 3-cycle row gap)
// checked against a cycle-arithmetic model of the raster feed and result tagging.
module tb_dog_scan_ctrl;

    localparam int W = 8, H = 6, OW = 2, OH = 2, DMAX = 20;
    localparam int NPIX = W * H, TOT = OW * OH;
    localparam int K_RD = 0, K_FD = 1, K_TAG = 2, K_DONE = 3;

    typedef struct {
        int inst;
        int kind;
        int cyc;
        int a;
        int b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, start, dog_valid;
    logic        busy_w [2], done_w [2], err_w [2], rd_w [2], vin_w [2], ov_w [2];
    logic [15:0] addr_w [2], col_w [2], row_w [2];
    logic [7:0]  rdata [2], din_w [2];
    logic [7:0]  img [NPIX];
    ev_t         evq [$];
    int          cyc = 0;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dog_scan_ctrl #(.WIDE(W), .HIGN(H), .DW(8), .AW(16), .CNT_DW(16), .OUT_W(OW), .OUT_H(OH),
                    .ROW_GAP(0), .DRAIN_MAX(DMAX)) u_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
        .frame_err(err_w[0]), .mem_rd_en(rd_w[0]), .mem_addr(addr_w[0]), .mem_rd_data(rdata[0]),
        .dog_valid_in(vin_w[0]), .dog_data_in(din_w[0]), .dog_valid(dog_valid),
        .out_valid(ov_w[0]), .out_col(col_w[0]), .out_row(row_w[0])
    );

    dog_scan_ctrl #(.WIDE(W), .HIGN(H), .DW(8), .AW(16), .CNT_DW(16), .OUT_W(OW), .OUT_H(OH),
                    .ROW_GAP(3), .DRAIN_MAX(DMAX)) u_g (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]),
        .frame_err(err_w[1]), .mem_rd_en(rd_w[1]), .mem_addr(addr_w[1]), .mem_rd_data(rdata[1]),
        .dog_valid_in(vin_w[1]), .dog_data_in(din_w[1]), .dog_valid(dog_valid),
        .out_valid(ov_w[1]), .out_col(col_w[1]), .out_row(row_w[1])
    );

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (rd_w[i]) rdata[i] <= img[int'(addr_w[i]) % NPIX];
    end

    function automatic void log_ev(input int i, input int k, input int a, input int b);
        ev_t ev;
        ev.inst = i; ev.kind = k; ev.cyc = cyc; ev.a = a; ev.b = b;
        evq.push_back(ev);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (rd_w[i])   log_ev(i, K_RD, int'(addr_w[i]), 0);
                if (vin_w[i])  log_ev(i, K_FD, int'(din_w[i]), 0);
                if (ov_w[i])   log_ev(i, K_TAG, int'(col_w[i]), int'(row_w[i]));
                if (done_w[i]) log_ev(i, K_DONE, 0, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: pixel p is read at s + p + gap*(p/W), fed one cycle later; result k is tagged
    // (k%OW, k/OW); done follows drain entry by one cycle when complete, else by DMAX cycles.
    task automatic check_frame(input int i, input int s, input int gap, input int emit);
        int nr = 0, nf = 0, nt = 0, nd = 0;
        int e, exp_done;
        e        = s + NPIX + gap * (H - 1);
        exp_done = (emit >= TOT) ? e + 1 : e + DMAX;
        foreach (evq[k]) begin
            if (evq[k].inst == i) begin
                case (evq[k].kind)
                    K_RD: begin
                        chk($sformatf("rd_addr%0d", i), evq[k].a, nr);
                        chk($sformatf("rd_cyc%0d", i), evq[k].cyc, s + nr + gap * (nr / W));
                        nr++;
                    end
                    K_FD: begin
                        if (nf < NPIX) chk($sformatf("feed_data%0d", i), evq[k].a, img[nf]);
                        chk($sformatf("feed_cyc%0d", i), evq[k].cyc, s + 1 + nf + gap * (nf / W));
                        nf++;
                    end
                    K_TAG: begin
                        chk($sformatf("tag_col%0d", i), evq[k].a, nt % OW);
                        chk($sformatf("tag_row%0d", i), evq[k].b, nt / OW);
                        nt++;
                    end
                    default: begin
                        chk($sformatf("done_cyc%0d", i), evq[k].cyc, exp_done);
                        nd++;
                    end
                endcase
            end
        end
        chk($sformatf("n_reads%0d", i), nr, NPIX);
        chk($sformatf("n_feeds%0d", i), nf, NPIX);
        chk($sformatf("n_tags%0d", i), nt, (emit < TOT) ? emit : TOT);
        chk($sformatf("n_done%0d", i), nd, 1);
    endtask

    task automatic wait_done(input int i, input bit drop_start);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (done_w[i]) seen = 1'b1;
        end
        if (drop_start) start = 1'b0;
        chk($sformatf("done_seen%0d", i), seen, 1'b1);
    endtask

    task automatic run_frame(input int emit, input bit hold, input bit complete);
        int s;
        evq.delete();
        start = 1'b1;
        s = cyc + 1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("start_busy%0d", i), busy_w[i], 1'b1);
            chk($sformatf("start_err_clr%0d", i), err_w[i], 1'b0);
            chk($sformatf("start_addr%0d", i), addr_w[i], 0);
        end
        if (!hold) start = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < emit; k++) begin
            dog_valid = 1'b1;
            tick();
            dog_valid = 1'b0;
            repeat ($urandom_range(0, 4)) tick();
        end
        wait_done(0, hold);
        wait_done(1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("end_busy%0d", i), busy_w[i], 1'b0);
            chk($sformatf("end_err%0d", i), err_w[i], !complete);
        end
        repeat (3) tick();
        check_frame(0, s, 0, emit);
        check_frame(1, s, 3, emit);
    endtask

    initial begin
        bit hit;
        rst = 1'b0; start = 1'b0; dog_valid = 1'b0;
        foreach (img[p]) img[p] = 8'($urandom);
        repeat (3) tick();
        chk("rst_busy", busy_w[0], 1'b0);
        chk("rst_done", done_w[0], 1'b0);
        chk("rst_err", err_w[0], 1'b0);
        chk("rst_rd_en", rd_w[0], 1'b0);
        chk("rst_addr", addr_w[0], 0);
        chk("rst_vin", vin_w[0], 1'b0);
        chk("rst_ov", ov_w[0], 1'b0);
        rst = 1'b1;
        repeat (2) tick();

        run_frame(4, 1'b0, 1'b1);
        run_frame(3, 1'b0, 1'b0);
        run_frame(4, 1'b0, 1'b1);

        // Result arriving with no frame in progress.
        tick();
        dog_valid = 1'b1;
        tick();
        dog_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("spur_err%0d", i), err_w[i], 1'b1);
            chk($sformatf("spur_ov%0d", i), ov_w[i], 1'b0);
        end
        tick();
        chk("spur_ov_late", ov_w[0], 1'b0);
        chk("spur_busy", busy_w[0], 1'b0);

        run_frame(4, 1'b1, 1'b1);

        // Reset in the middle of a frame, after two results have been tagged.
        evq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            dog_valid = 1'b1;
            tick();
            dog_valid = 1'b0;
        end
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            if (addr_w[0] == 16'd20) hit = 1'b1;
            else tick();
        end
        chk("reach_addr20", hit, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", busy_w[0], 1'b0);
        chk("mid_done", done_w[0], 1'b0);
        chk("mid_rd_en", rd_w[0], 1'b0);
        chk("mid_addr", addr_w[0], 0);
        chk("mid_vin", vin_w[0], 1'b0);
        chk("mid_din", din_w[0], 0);
        chk("mid_ov", ov_w[0], 1'b0);
        chk("mid_col", col_w[0], 0);
        chk("mid_row", row_w[0], 0);
        chk("mid_err", err_w[0], 1'b0);
        chk("mid_busy_g", busy_w[1], 1'b0);
        chk("mid_addr_g", addr_w[1], 0);
        tick();
        rst = 1'b1;
        tick();
        run_frame(4, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
